// File: rtl/ro_reg_bank.sv
// ro_reg_bank: read-only status register bank with live and sticky read-to-clear registers.
// Optional even-parity output o_rpar when RO_REG_BANK_PARITY_EN is defined.
module ro_reg_bank #(
  parameter int                 DW                   = 8,
  parameter int                 AW                   = 8,
  parameter int                 NUM_REG              = 4,
  parameter logic [AW-1:0]      BASE_ADDR            = {AW{1'b0}},
  parameter logic [NUM_REG-1:0] RC_MASK              = {NUM_REG{1'b0}},
  parameter logic               SUPPORT_TEST_MODE_RD = 1'b1,
  parameter logic               SUPPORT_CFG_MODE_RD  = 1'b1,
  parameter logic               SUPPORT_SPI_EN_RD    = 1'b1,
  parameter int                 END_OF_LIST          = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ren,
  input  logic                  i_test_st_reg_en,
  input  logic                  i_cfg_st_reg_en,
  input  logic                  i_spi_ctrl_reg_en,
  input  logic [AW-1:0]         i_addr,
  input  logic [NUM_REG*DW-1:0] i_ff_data,
  output logic [DW-1:0]         o_rdata,
  output logic                  o_rvalid,
`ifdef RO_REG_BANK_PARITY_EN
  output logic                  o_rpar,
`endif
  output logic [NUM_REG*DW-1:0] o_sticky
);
  if (longint'(BASE_ADDR) + longint'(NUM_REG) > (longint'(1) << AW)) begin : g_range_err
    $error("ro_reg_bank: register range wraps the address space (END_OF_LIST=%0d)", END_OF_LIST);
  end
  logic [NUM_REG-1:0][DW-1:0] ff, sticky_q, sticky_d;
  logic [DW-1:0] rdata_q, rdata_d, val;
  logic [AW-1:0] idx;
  logic hit, ren, rvalid_q, sel;
  assign ff  = i_ff_data;
  assign idx = i_addr - BASE_ADDR;
  assign hit = (i_addr >= BASE_ADDR) && ({1'b0, idx} < (AW+1)'(NUM_REG));
  assign ren = i_ren & hit & ((i_test_st_reg_en & SUPPORT_TEST_MODE_RD) |
                              (i_cfg_st_reg_en & SUPPORT_CFG_MODE_RD) |
                              (i_spi_ctrl_reg_en & SUPPORT_SPI_EN_RD));
  // Same-cycle events are folded into the read value and the sticky is cleared, so nothing is lost or duplicated.
  always_comb begin
    sticky_d = '0;
    rdata_d  = '0;
    val      = '0;
    sel      = 1'b0;
    for (int k = 0; k < NUM_REG; k++) begin
      val = RC_MASK[k] ? (sticky_q[k] | ff[k]) : ff[k];
      sel = ren && (idx == AW'(k));
      rdata_d = sel ? val : rdata_d;
      sticky_d[k] = (RC_MASK[k] && !sel) ? val : '0;
    end
  end
  always_ff @(posedge i_clk) begin
    sticky_q <= !i_rst_n ? '0 : sticky_d;
    rdata_q  <= !i_rst_n ? '0 : rdata_d;
    rvalid_q <= !i_rst_n ? 1'b0 : ren;
  end
  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_sticky = sticky_q;
`ifdef RO_REG_BANK_PARITY_EN
  logic rpar_q;
  always_ff @(posedge i_clk) begin
    rpar_q <= !i_rst_n ? 1'b0 : ^rdata_d;
  end
  assign o_rpar = rpar_q;
`endif
endmodule

// File: doc/ro_reg_bank.md
Name: ro_reg_bank

Overview:
Parametrised bank of NUM_REG read-only status registers at consecutive addresses starting at BASE_ADDR, for the register-file read mux.
- Each register is either a live register (plain sample of inner-logic flops) or a sticky read-to-clear (RC) event register, selected per register by RC_MASK.
- Read data is registered: one cycle of latency, with a valid strobe. Zero is returned on miss so outputs can be OR-combined on the read bus.

Parameters:
- DW, 8, register data width.
- AW, 8, address width.
- NUM_REG, 4, number of registers in the bank (1..2^AW).
- BASE_ADDR, {AW{1'b0}}, address of register 0; register k sits at BASE_ADDR+k.
- RC_MASK, {NUM_REG{1'b0}}, bit k=1 makes register k sticky read-to-clear; 0 makes it live.
- SUPPORT_TEST_MODE_RD, 1'b1, reads allowed while i_test_st_reg_en=1.
- SUPPORT_CFG_MODE_RD, 1'b1, reads allowed while i_cfg_st_reg_en=1.
- SUPPORT_SPI_EN_RD, 1'b1, reads allowed while i_spi_ctrl_reg_en=1.
- END_OF_LIST, 1, list terminator, unused.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_ren  input  1  read strobe; each high cycle is one read.
- i_test_st_reg_en  input  1  test-state access enable.
- i_cfg_st_reg_en  input  1  config-state access enable.
- i_spi_ctrl_reg_en  input  1  SPI-control access enable.
- i_addr  input  AW  read address.
- i_ff_data  input  NUM_REG*DW  register k in slice [k*DW +: DW]; live value or event pulses (RC).
- o_rdata  output  DW  registered read data; 0 when not valid.
- o_rvalid  output  1  high one cycle after an accepted read.
- o_sticky  output  NUM_REG*DW  current sticky state; RC slices only, live slices tied 0.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is synchronous, active-low.
- Reset values: o_rdata=0, o_rvalid=0, all sticky bits=0. Reset has priority over read and set in the same cycle.
- Hit and index:
  - hit = BASE_ADDR <= i_addr <= BASE_ADDR+NUM_REG-1.
  - idx = i_addr-BASE_ADDR, computed in AW bits.
  - Elaboration error if BASE_ADDR+NUM_REG-1 > 2^AW-1 (no address wrap).
- Accepted read: ren = i_ren & hit & ((i_test_st_reg_en&SUPPORT_TEST_MODE_RD) | (i_cfg_st_reg_en&SUPPORT_CFG_MODE_RD) | (i_spi_ctrl_reg_en&SUPPORT_SPI_EN_RD)).
- Latency: ren in cycle N gives o_rvalid=1 and o_rdata valid in cycle N+1.
- Live register k: o_rdata <= i_ff_data[k] as sampled at the cycle-N edge.
- RC register k, every cycle without a read of it: sticky_k <= sticky_k | i_ff_data[k].
- RC register k, read in cycle N:
  - o_rdata <= sticky_k | i_ff_data[k]; same-cycle events are reported.
  - sticky_k <= 0.
  - No event is lost or reported twice.
- No accepted read: o_rdata <= 0, o_rvalid <= 0.
  - Covers miss, gated mode, and i_ren=0.
  - No sticky clear occurs; sticky keeps accumulating.
- Back-to-back reads: i_ren held high gives one read per cycle.
  - An RC register re-read on consecutive cycles returns only events that arrived since the previous read.
- Sticky isolation: a read of register j does not affect the sticky state of register k (k≠j).
- Address or enable changes mid-read: sampled only at the clock edge; no hold requirement beyond setup.

Optional Feature:
- Macro: RO_REG_BANK_PARITY_EN.
- Defined:
  - Adds output o_rpar (1 bit) = ^o_rdata (even parity), registered with o_rdata.
  - Reset value 0; 0 whenever o_rvalid=0.
- Not defined: port o_rpar and its logic are absent; all other behaviour is identical.

Test Plan:
Common setup: DW=8, NUM_REG=4, BASE_ADDR=8'h10, RC_MASK=4'b1010.
1. Live read: i_ff_data slice0=8'hA5, i_cfg_st_reg_en=1, i_ren=1, i_addr=8'h10 for 1 cycle -> next cycle o_rvalid=1, o_rdata=8'hA5; following cycle o_rdata=0, o_rvalid=0.
2. RC accumulate and clear:
   - Stimulus: pulse slice1=8'h01 in cycle 1 and 8'h04 in cycle 3; read 8'h11 in cycle 5.
   - Response: o_rdata=8'h05 in cycle 6, o_sticky slice1=0 afterwards. A second read of 8'h11 returns 8'h00 with o_rvalid=1.
3. Simultaneous set and read: slice3 sticky=8'h10, pulse 8'h80 in the same cycle as a read of 8'h13 -> o_rdata=8'h90, sticky slice3=0 after the read.
4. Miss and gating:
   - Read 8'h14 with cfg enable -> o_rvalid=0, o_rdata=0.
   - SUPPORT_SPI_EN_RD=0, only i_spi_ctrl_reg_en=1, read 8'h11 with sticky=8'h02 -> o_rvalid=0, sticky stays 8'h02.
5. Reset mid-operation: sticky slice1=8'hFF, assert i_rst_n=0 in the same cycle as a read of 8'h11 -> next cycle o_rvalid=0, o_rdata=0, o_sticky=0.
6. Parity (RO_REG_BANK_PARITY_EN defined): live slice2=8'h07, read 8'h12 -> o_rdata=8'h07, o_rpar=1; slice2=8'h03 -> o_rpar=0.
